gun_sensor_ctl: RTL and testbench
=================================

GUN_SENSOR_CTL -- requirements
Module: gun_sensor_ctl

Interface
REQ-001 Parameter N_CH, default 2: number of light guns, legal range 1..4.
REQ-002 Parameter AUX_BASE, default 4: XADC VAUX index of gun 0; gun g uses VAUX(AUX_BASE+g).
REQ-003 Parameter THRESH_HI, default 12'd2048: light-detect upper threshold.
REQ-004 Parameter THRESH_LO, default 12'd1536: light-detect lower threshold; SHALL be <= THRESH_HI.
REQ-005 Parameter DEB_CYC, default 500000: trigger debounce length in clk cycles.
REQ-006 Parameter TIMEOUT, default 64: DRP ready-wait limit in clk cycles.
REQ-007 clk  in  1  single system clock; also drives XADC dclk_in.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 eoc_in  in  1  XADC end-of-conversion pulse.
REQ-010 channel_in  in  5  XADC channel of the finished conversion.
REQ-011 do_in  in  16  XADC DRP read data.
REQ-012 drdy_in  in  1  XADC DRP data-ready.
REQ-013 daddr_out  out  7  DRP address.
REQ-014 den_out  out  1  DRP enable, one-cycle pulse.
REQ-015 dwe_out  out  1  DRP write enable; held 0.
REQ-016 di_out  out  16  DRP write data; held 0.
REQ-017 trig_n  in  N_CH  raw trigger switches, active-low, asynchronous.
REQ-018 sample  out  12*N_CH  latest 12-bit ADC result per gun; gun g at bits [12g+11:12g].
REQ-019 sample_valid  out  N_CH  one-cycle pulse when sample[g] updates.
REQ-020 light  out  N_CH  per-gun light-detected level.
REQ-021 trig_pulse  out  N_CH  one-cycle pulse on each debounced trigger press.
REQ-022 drp_err  out  1  sticky: a DRP read timed out.

Function
REQ-023 DRP FSM states: IDLE, READ, WAIT_RDY.
REQ-024 IDLE: on eoc_in=1 with channel_in in [16+AUX_BASE, 16+AUX_BASE+N_CH-1], latch the gun index and go to READ; all other channels are ignored.
REQ-025 READ: den_out=1 for exactly one cycle, daddr_out={2'b00,channel_in latched}; next state WAIT_RDY.
REQ-026 WAIT_RDY: on drdy_in=1, store do_in[15:4] into sample[g], pulse sample_valid[g] the following cycle, return to IDLE.
REQ-027 WAIT_RDY: if drdy_in is absent for TIMEOUT cycles, set drp_err, keep the old sample, and return to IDLE.
REQ-028 eoc_in arriving outside IDLE SHALL be dropped, with no queueing.
REQ-029 Latency from eoc_in to sample_valid SHALL be 3 cycles plus the XADC drdy delay.
REQ-030 light[g] SHALL update in the same cycle as sample_valid[g], per REQ-041/042.
REQ-031 trig_n[g] SHALL pass through a 2-flop synchroniser before use.
REQ-032 Debounce: the synchronised level must hold stable for DEB_CYC consecutive cycles before the debounced state changes; any toggle restarts the counter.
REQ-033 trig_pulse[g] SHALL fire one cycle after the debounced state goes from released to pressed; no pulse on release.
REQ-034 Each gun's debounce logic is independent; simultaneous presses SHALL yield simultaneous pulses.
REQ-035 Debounce counter width SHALL be clog2(DEB_CYC+1), and it SHALL saturate with no wrap.

Reset
REQ-036 While rst_n=0: FSM in IDLE, and den_out, dwe_out, di_out, daddr_out, sample, sample_valid, light, trig_pulse, drp_err are all 0.
REQ-037 Debounced state resets to released, and synchronisers reset to 1 (released), so release of reset SHALL NOT create a trig_pulse.
REQ-038 Reset asserted mid-read SHALL abort the transaction; a drdy_in arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-039 Macro GUN_SENSOR_HYST_EN selects the light comparator.
REQ-040 Without the macro: light[g] = (sample[g] >= THRESH_HI).
REQ-041 With the macro, light[g] rises when sample[g] >= THRESH_HI and falls when sample[g] < THRESH_LO.
REQ-042 With the macro, light[g] otherwise holds its value.

Verification
REQ-043 eoc_in with channel_in=5'h14, then drdy_in 4 cycles later with do_in=16'hABC0 -> den_out pulses once with daddr_out=7'h14, sample[11:0]=12'hABC, sample_valid[0] pulses once.
REQ-044 channel_in=5'h10 with eoc_in -> den_out stays 0 and no sample_valid.
REQ-045 READ then no drdy_in for 64 cycles -> drp_err=1, FSM back in IDLE, sample unchanged; the next valid eoc_in reads normally.
REQ-046 Hysteresis on, samples 2100, 1800, 1500 on gun 1 -> light[1] = 1, 1, 0; hysteresis off, same samples -> 1, 0, 0.
REQ-047 DEB_CYC=8, trig_n[0] bounces low-high-low at 3-cycle spacing then holds low -> exactly one trig_pulse[0], 8 cycles after the final low plus 2 synchroniser cycles; release produces no pulse.
REQ-048 rst_n pulsed low during WAIT_RDY, then drdy_in after release -> all outputs 0, no sample_valid, no den_out.

Source files
------------

// File: rtl/gun_sensor_if.sv
// XADC DRP / end-of-conversion bundle between the light-gun controller and the XADC primitive.
interface gun_sensor_if;
    logic        eoc_in;
    logic [4:0]  channel_in;
    logic [15:0] do_in;
    logic        drdy_in;
    logic [6:0]  daddr_out;
    logic        den_out;
    logic        dwe_out;
    logic [15:0] di_out;

    modport master (
        input  eoc_in, channel_in, do_in, drdy_in,
        output daddr_out, den_out, dwe_out, di_out
    );

    modport slave (
        output eoc_in, channel_in, do_in, drdy_in,
        input  daddr_out, den_out, dwe_out, di_out
    );
endinterface

// File: rtl/gun_sensor_ctl.sv
// Light-gun sensor controller: XADC DRP readout of per-gun photodiode samples plus trigger debounce.
// Define GUN_SENSOR_HYST_EN to use the two-threshold (hysteresis) light comparator.
module gun_sensor_ctl #(
    parameter int          N_CH      = 2,
    parameter int          AUX_BASE  = 4,
    parameter logic [11:0] THRESH_HI = 12'd2048,
    parameter logic [11:0] THRESH_LO = 12'd1536,
    parameter int          DEB_CYC   = 500000,
    parameter int          TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gun_sensor_if.master         drp,
    input  logic [N_CH-1:0]      trig_n,
    output logic [12*N_CH-1:0]   sample,
    output logic [N_CH-1:0]      sample_valid,
    output logic [N_CH-1:0]      light,
    output logic [N_CH-1:0]      trig_pulse,
    output logic                 drp_err
);

    localparam int          GW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int          TW    = $clog2(TIMEOUT + 1);
    localparam int          CW    = $clog2(DEB_CYC + 1);
    localparam logic [4:0]  CH_LO = 5'(16 + AUX_BASE);
    localparam logic [4:0]  CH_HI = 5'(16 + AUX_BASE + N_CH - 1);

    typedef enum logic [1:0] {IDLE, READ, WAIT_RDY} state_t;

    state_t          state, next_state;
    logic [4:0]      ch_q;
    logic [GW-1:0]   gun_q;
    logic [TW-1:0]   tmo_cnt;
    logic            hit;
    logic            timed_out;
    logic [11:0]     rd_val;

    assign hit       = drp.eoc_in && (drp.channel_in >= CH_LO) && (drp.channel_in <= CH_HI);
    assign timed_out = (tmo_cnt == TW'(TIMEOUT - 1));
    assign rd_val    = drp.do_in[15:4];

    assign drp.daddr_out = {2'b00, ch_q};
    assign drp.dwe_out   = 1'b0;
    assign drp.di_out    = '0;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        next_state  = state;
        drp.den_out = 1'b0;
        case (state)
            IDLE:     if (hit) next_state = READ;
            READ: begin
                drp.den_out = 1'b1;
                next_state  = WAIT_RDY;
            end
            WAIT_RDY: if (drp.drdy_in || timed_out) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // NOTE: the sample store is a handful of registers that must read 0 in reset, so it is reset explicitly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q         <= '0;
            gun_q        <= '0;
            tmo_cnt      <= '0;
            sample       <= '0;
            sample_valid <= '0;
            light        <= '0;
            drp_err      <= 1'b0;
        end else begin
            sample_valid <= '0;
            case (state)
                IDLE: if (hit) begin
                    ch_q  <= drp.channel_in;
                    gun_q <= GW'(drp.channel_in - CH_LO);
                end
                READ: tmo_cnt <= '0;
                WAIT_RDY: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (drp.drdy_in) begin
                        for (int g = 0; g < N_CH; g++) begin
                            if (gun_q == GW'(g)) begin
                                sample[12*g +: 12] <= rd_val;
                                sample_valid[g]    <= 1'b1;
`ifdef GUN_SENSOR_HYST_EN
                                if (rd_val >= THRESH_HI)      light[g] <= 1'b1;
                                else if (rd_val < THRESH_LO)  light[g] <= 1'b0;
`else
                                light[g] <= (rd_val >= THRESH_HI);
`endif
                            end
                        end
                    end else if (timed_out) begin
                        drp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-gun trigger path: 2-flop synchroniser, stability counter, press-edge pulse.
    for (genvar g = 0; g < N_CH; g++) begin : g_trig
        logic          s1, s2, deb, deb_d, pulse_q;
        logic [CW-1:0] cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1      <= 1'b1;
                s2      <= 1'b1;
                deb     <= 1'b1;
                deb_d   <= 1'b1;
                cnt     <= '0;
                pulse_q <= 1'b0;
            end else begin
                s1      <= trig_n[g];
                s2      <= s1;
                deb_d   <= deb;
                pulse_q <= deb_d && !deb;
                if (s2 == deb) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_CYC - 1)) begin
                    deb <= s2;
                    cnt <= '0;
                end else if (cnt != CW'(DEB_CYC)) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign trig_pulse[g] = pulse_q;
    end

endmodule

// File: tb/tb_gun_sensor_ctl.sv
// Scoreboard bench for gun_sensor_ctl: directed DRP reads, timeout, light thresholds, debounce, reset abort.
module tb_gun_sensor_ctl;

    localparam int N_CH = 2;
    localparam int DEB  = 8;

    typedef enum int {EV_DEN, EV_SAMPLE, EV_TRIG} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        int          gun;
        logic [11:0] data;
        logic        lt;
        int          cyc;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_CH-1:0]      trig_n = '1;
    logic [12*N_CH-1:0]   sample;
    logic [N_CH-1:0]      sample_valid;
    logic [N_CH-1:0]      light;
    logic [N_CH-1:0]      trig_pulse;
    logic                 drp_err;

    int    vectors = 0;
    int    miscompares = 0;
    int    cyc = 0;
    ev_t   exp_q[$];
    logic  exp_lt [N_CH];

    gun_sensor_if xif ();

    gun_sensor_ctl #(
        .N_CH(N_CH), .AUX_BASE(4), .THRESH_HI(12'd2048), .THRESH_LO(12'd1536),
        .DEB_CYC(DEB), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .drp(xif.master), .trig_n(trig_n),
        .sample(sample), .sample_valid(sample_valid), .light(light),
        .trig_pulse(trig_pulse), .drp_err(drp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic model_light(input logic old, input logic [11:0] v);
`ifdef GUN_SENSOR_HYST_EN
        if (v >= 12'd2048)     return 1'b1;
        else if (v < 12'd1536) return 1'b0;
        else                   return old;
`else
        return (v >= 12'd2048) ? 1'b1 : (old & 1'b0);
`endif
    endfunction

    task automatic push(input ev_kind_t k, input int gun, input logic [11:0] data, input logic lt, input int c);
        ev_t e;
        e.kind = k; e.gun = gun; e.data = data; e.lt = lt; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic observe(input ev_kind_t k, input int gun, input logic [11:0] data, input logic lt);
        ev_t e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d gun %0d data %0h, required none (cycle %0d)", k, gun, data, cyc);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", k, e.kind);
            check("ev_gun", gun, e.gun);
            check("ev_data", {20'd0, data}, {20'd0, e.data});
            check("ev_light", {31'd0, lt}, {31'd0, e.lt});
            if (e.cyc >= 0) check("ev_cycle", cyc, e.cyc);
        end
    endtask

    // Monitor: every DUT output event is matched against the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (xif.den_out) observe(EV_DEN, 0, {5'd0, xif.daddr_out}, 1'b0);
            for (int g = 0; g < N_CH; g++)
                if (sample_valid[g]) observe(EV_SAMPLE, g, sample[12*g +: 12], light[g]);
            for (int g = 0; g < N_CH; g++)
                if (trig_pulse[g]) observe(EV_TRIG, g, 12'd0, 1'b0);
        end
    end

    task automatic eoc_pulse(input logic [4:0] ch);
        @(negedge clk);
        xif.eoc_in = 1'b1; xif.channel_in = ch;
        @(negedge clk);
        xif.eoc_in = 1'b0;
    endtask

    task automatic drdy_pulse(input logic [15:0] data);
        xif.drdy_in = 1'b1; xif.do_in = data;
        @(negedge clk);
        xif.drdy_in = 1'b0;
    endtask

    // Full read: drdy arrives dly cycles after eoc (dly >= 2).
    task automatic do_read(input logic [4:0] ch, input logic [15:0] data, input int dly);
        int g;
        g = int'(ch) - 20;
        push(EV_DEN, 0, {5'd0, ch}, 1'b0, -1);
        eoc_pulse(ch);
        repeat (dly - 1) @(negedge clk);
        exp_lt[g] = model_light(exp_lt[g], data[15:4]);
        push(EV_SAMPLE, g, data[15:4], exp_lt[g], -1);
        drdy_pulse(data);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_den"}, {31'd0, xif.den_out}, 32'd0);
        check({tag, "_daddr"}, {25'd0, xif.daddr_out}, 32'd0);
        check({tag, "_dwe"}, {31'd0, xif.dwe_out}, 32'd0);
        check({tag, "_di"}, {16'd0, xif.di_out}, 32'd0);
        check({tag, "_sample"}, {8'd0, sample}, 32'd0);
        check({tag, "_sample_valid"}, {30'd0, sample_valid}, 32'd0);
        check({tag, "_light"}, {30'd0, light}, 32'd0);
        check({tag, "_trig_pulse"}, {30'd0, trig_pulse}, 32'd0);
        check({tag, "_drp_err"}, {31'd0, drp_err}, 32'd0);
    endtask

    initial begin
        int c0;
        xif.eoc_in = 1'b0; xif.channel_in = '0; xif.do_in = '0; xif.drdy_in = 1'b0;
        for (int g = 0; g < N_CH; g++) exp_lt[g] = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_trig_after_reset", {30'd0, trig_pulse}, 32'd0);

        // Basic read on gun 0, drdy 4 cycles after eoc.
        do_read(5'h14, 16'hABC0, 4);
        check("gun0_sample", {20'd0, sample[11:0]}, 32'hABC);

        // Channels outside the gun window are ignored.
        eoc_pulse(5'h10);
        eoc_pulse(5'h13);
        eoc_pulse(5'h16);
        repeat (4) @(negedge clk);

        // eoc during WAIT_RDY is dropped.
        push(EV_DEN, 0, 12'h015, 1'b0, -1);
        eoc_pulse(5'h15);
        @(negedge clk);
        xif.eoc_in = 1'b1; xif.channel_in = 5'h14;
        @(negedge clk);
        xif.eoc_in = 1'b0;
        @(negedge clk);
        exp_lt[1] = model_light(exp_lt[1], 12'h123);
        push(EV_SAMPLE, 1, 12'h123, exp_lt[1], -1);
        drdy_pulse(16'h1230);
        repeat (6) @(negedge clk);

        // DRP timeout keeps the old sample and sets the sticky error.
        push(EV_DEN, 0, 12'h014, 1'b0, -1);
        eoc_pulse(5'h14);
        repeat (59) @(negedge clk);
        check("drp_err_before_timeout", {31'd0, drp_err}, 32'd0);
        repeat (10) @(negedge clk);
        check("drp_err_after_timeout", {31'd0, drp_err}, 32'd1);
        check("sample_kept_on_timeout", {20'd0, sample[11:0]}, 32'hABC);
        do_read(5'h14, 16'h5550, 3);
        check("read_after_timeout", {20'd0, sample[11:0]}, 32'h555);

        // Light comparator on gun 1: 2100, 1800, 1500.
        do_read(5'h15, 16'(12'd2100) << 4, 2);
        do_read(5'h15, 16'(12'd1800) << 4, 5);
        do_read(5'h15, 16'(12'd1500) << 4, 3);
        check("gun1_final_light", {31'd0, light[1]}, 32'd0);

        // Bouncing press on gun 0, then hold and release.
        @(negedge clk); trig_n[0] = 1'b0;
        repeat (3) @(negedge clk); trig_n[0] = 1'b1;
        repeat (3) @(negedge clk);
        trig_n[0] = 1'b0;
        c0 = cyc;
        push(EV_TRIG, 0, 12'd0, 1'b0, c0 + DEB + 3);
        repeat (25) @(negedge clk);
        trig_n[0] = 1'b1;
        repeat (25) @(negedge clk);

        // Simultaneous presses pulse together.
        trig_n = '0;
        c0 = cyc;
        push(EV_TRIG, 0, 12'd0, 1'b0, c0 + DEB + 3);
        push(EV_TRIG, 1, 12'd0, 1'b0, c0 + DEB + 3);
        repeat (20) @(negedge clk);
        trig_n = '1;
        repeat (20) @(negedge clk);

        // Reset mid-read: transaction aborted, late drdy ignored.
        push(EV_DEN, 0, 12'h014, 1'b0, -1);
        eoc_pulse(5'h14);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int g = 0; g < N_CH; g++) exp_lt[g] = 1'b0;
        @(negedge clk);
        check_reset_outputs("midread_reset");
        rst_n = 1'b1;
        @(negedge clk);
        drdy_pulse(16'hFFF0);
        repeat (5) @(negedge clk);
        check("sample_after_abort", {8'd0, sample}, 32'd0);
        check("drp_err_after_abort", {31'd0, drp_err}, 32'd0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
